// File: rtl/watchdog_pkg.sv
// Shared types and constant helpers for the watchdog supervisor slice.
package watchdog_pkg;

  typedef enum logic [2:0] {
    stIdle    = 3'd0,
    stArmed   = 3'd1,
    stRun     = 3'd2,
    stTrip    = 3'd3,
    stLockout = 3'd4
  } wdState_e;

  localparam logic [7:0] RetrySaturate = 8'hFF;

  // Number of bits needed to hold the values 0 .. value-1.
  function automatic int unsigned clog2(input longint unsigned value);
    longint unsigned span;
    int unsigned bits;
    span = (value > 64'd0) ? value - 64'd1 : 64'd0;
    bits = 0;
    while (span > 64'd0) begin
      bits++;
      span = span >> 1;
    end
    return bits;
  endfunction

  // 64-bit product keeps large clock rates with long windows from overflowing.
  function automatic longint unsigned msToCycles(input longint unsigned freqHz,
                                                 input longint unsigned ms);
    return (freqHz * ms) / 64'd1000;
  endfunction

endpackage

// File: rtl/watchdog_supervisor_if.sv
// Heartbeat/control and status bundle between the supervised system and the supervisor.
interface watchdog_supervisor_if;

  logic       ipEnable;
  logic       ipKick;
  logic       ipClearFault;
  logic       opSysReset;
  logic       opFault;
  logic       opTimeout;
  logic [7:0] opRetryCount;
  logic [2:0] opState;

  modport master (
    output ipEnable, ipKick, ipClearFault,
    input  opSysReset, opFault, opTimeout, opRetryCount, opState
  );

  modport slave (
    input  ipEnable, ipKick, ipClearFault,
    output opSysReset, opFault, opTimeout, opRetryCount, opState
  );

endinterface

// File: rtl/kick_edge_detect.sv
// Two-flop rising-edge detector; pulses for one cycle, one cycle after the level rises.
module kick_edge_detect (
  input  logic ipClk,
  input  logic ipReset,
  input  logic ipLevel,
  output logic opPulse
);

  logic [1:0] levelHistory;

  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      levelHistory <= 2'b00;
    end else begin
      levelHistory <= {levelHistory[0], ipLevel};
    end
  end

  assign opPulse = (levelHistory == 2'b01);

endmodule

// File: rtl/watchdog_supervisor.sv
// Heartbeat watchdog: grace window, kick timeout, fixed reset pulse and lockout after repeated trips.
module watchdog_supervisor
  import watchdog_pkg::*;
#(
  parameter int unsigned Clk_Frequency    = 50000000,
  parameter int unsigned Timeout_ms       = 100,
  parameter int unsigned Grace_ms         = 500,
  parameter int unsigned ResetHold_cycles = 1024,
  parameter int unsigned MaxRetries       = 3
) (
  input logic ipClk,
  input logic ipReset,
  watchdog_supervisor_if.slave bus
);

  localparam longint unsigned TimeoutCycles = msToCycles(64'(Clk_Frequency), 64'(Timeout_ms));
  localparam longint unsigned GraceCycles   = msToCycles(64'(Clk_Frequency), 64'(Grace_ms));
  localparam longint unsigned HoldCycles    = 64'(ResetHold_cycles);
  localparam longint unsigned MaxCycles =
    (TimeoutCycles > GraceCycles) ?
      ((TimeoutCycles > HoldCycles) ? TimeoutCycles : HoldCycles) :
      ((GraceCycles > HoldCycles) ? GraceCycles : HoldCycles);
  localparam int unsigned CntWidth = (clog2(MaxCycles) < 1) ? 1 : clog2(MaxCycles);

  localparam logic [CntWidth-1:0] timeoutLoad = CntWidth'(TimeoutCycles - 64'd1);
  localparam logic [CntWidth-1:0] graceLoad   = CntWidth'(GraceCycles - 64'd1);
  localparam logic [CntWidth-1:0] holdLoad    = CntWidth'(HoldCycles - 64'd1);
  localparam logic [CntWidth-1:0] cntOne      = CntWidth'(1);
  localparam logic [7:0]          retryLimit  = 8'(MaxRetries);

  if (TimeoutCycles < 64'd1 || GraceCycles < 64'd1 || HoldCycles < 64'd1 ||
      MaxRetries < 1 || MaxRetries > 255) begin : gParamCheck
    $error("watchdog_supervisor: derived cycle counts must be >= 1 and MaxRetries 1..255");
  end

  wdState_e          state;
  logic [CntWidth-1:0] count;
  logic [7:0]        retryCount;
  logic              sysReset;
  logic              fault;
  logic              timeoutPulse;
  logic              kick;

  kick_edge_detect uKickEdge (
    .ipClk   (ipClk),
    .ipReset (ipReset),
    .ipLevel (bus.ipKick),
    .opPulse (kick)
  );

  // One shared down-counter serves the grace, kick-timeout and reset-hold windows;
  // a kick on the expiry cycle always beats the trip.
  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      state        <= stIdle;
      count        <= '0;
      retryCount   <= '0;
      sysReset     <= 1'b0;
      fault        <= 1'b0;
      timeoutPulse <= 1'b0;
    end else begin
      timeoutPulse <= 1'b0;
      unique case (state)
        stIdle: begin
          if (bus.ipEnable) begin
            state <= stArmed;
            count <= graceLoad;
          end
        end
        stArmed, stRun: begin
          if (!bus.ipEnable) begin
            state <= stIdle;
          end else if (kick) begin
            state <= stRun;
            count <= timeoutLoad;
            if (state == stArmed) retryCount <= '0;
          end else if (count == '0) begin
            state        <= stTrip;
            count        <= holdLoad;
            sysReset     <= 1'b1;
            timeoutPulse <= 1'b1;
            retryCount   <= (retryCount == RetrySaturate) ? retryCount : retryCount + 8'd1;
          end else begin
            count <= count - cntOne;
          end
        end
        stTrip: begin
          if (count == '0) begin
            if (retryCount >= retryLimit) begin
              state <= stLockout;
              fault <= 1'b1;
            end else begin
              state    <= bus.ipEnable ? stArmed : stIdle;
              count    <= graceLoad;
              sysReset <= 1'b0;
            end
          end else begin
            count <= count - cntOne;
          end
        end
        stLockout: begin
          if (bus.ipClearFault) begin
            state      <= stArmed;
            count      <= graceLoad;
            retryCount <= '0;
            sysReset   <= 1'b0;
            fault      <= 1'b0;
          end
        end
        default: begin
          state    <= stIdle;
          sysReset <= 1'b0;
          fault    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.opSysReset   = sysReset;
  assign bus.opFault      = fault;
  assign bus.opTimeout    = timeoutPulse;
  assign bus.opRetryCount = retryCount;
  assign bus.opState      = state;

endmodule
